// File: rtl/phys_reg_file_pkg.sv
// rtl/phys_reg_file_pkg.sv - shared constants and types for the physical register file
package phys_reg_file_pkg;

    localparam int NUM_PREGS = 128;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int XLEN      = 32;
    localparam int NUM_RD    = 2;

    // Physical register tag; also used by write-back result dest and rename.
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/phys_reg_file_if.sv
// rtl/phys_reg_file_if.sv - write-back, rename, operand-read and wakeup signals of the register file
interface phys_reg_file_if;
    import phys_reg_file_pkg::*;

    preg_t                    write_addr;    // write-back tag, 0 = idle
    xlen_t                    write_data;
    logic                     alloc_valid;   // rename marks alloc_addr busy
    preg_t                    alloc_addr;
    preg_t [NUM_RD-1:0]       rd_addr;
    xlen_t [NUM_RD-1:0]       rd_data;       // one cycle after rd_addr
    logic  [NUM_RD-1:0]       rd_ready;
    logic                     wakeup_valid;  // a tag was written last cycle
    preg_t                    wakeup_tag;

    modport master (
        output write_addr, write_data, alloc_valid, alloc_addr, rd_addr,
        input  rd_data, rd_ready, wakeup_valid, wakeup_tag
    );

    modport slave (
        input  write_addr, write_data, alloc_valid, alloc_addr, rd_addr,
        output rd_data, rd_ready, wakeup_valid, wakeup_tag
    );

endinterface

// File: rtl/preg_scoreboard.sv
// rtl/preg_scoreboard.sv - busy bit per physical tag with alloc-over-write priority
module preg_scoreboard
    import phys_reg_file_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  preg_t              clr_addr,     // write-back tag, clears busy
    input  logic               set_valid,
    input  preg_t              set_addr,     // rename tag, sets busy
    input  preg_t [NUM_RD-1:0] lookup_addr,
    output logic  [NUM_RD-1:0] lookup_busy   // pre-update busy state
);

    logic [NUM_PREGS-1:0] busy_q;
    logic [NUM_PREGS-1:0] busy_d;

    // Set is applied after clear so a same-tag allocate leaves the tag busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_addr != '0) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_valid && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        lookup_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            lookup_busy[i] = busy_q[lookup_addr[i]];
        end
    end

endmodule

// File: rtl/phys_reg_file.sv
// rtl/phys_reg_file.sv - physical register file with busy scoreboard, write bypass and wakeup broadcast
module phys_reg_file
    import phys_reg_file_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    phys_reg_file_if.slave bus
);

    xlen_t              mem_q [NUM_PREGS];
    logic               mem_we;
    logic  [NUM_RD-1:0] busy_rd;

    xlen_t [NUM_RD-1:0] rd_data_d;
    xlen_t [NUM_RD-1:0] rd_data_q;
    logic  [NUM_RD-1:0] rd_ready_d;
    logic  [NUM_RD-1:0] rd_ready_q;
    logic               wakeup_valid_d;
    logic               wakeup_valid_q;
    preg_t              wakeup_tag_d;
    preg_t              wakeup_tag_q;

    preg_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .clr_addr    (bus.write_addr),
        .set_valid   (bus.alloc_valid),
        .set_addr    (bus.alloc_addr),
        .lookup_addr (bus.rd_addr),
        .lookup_busy (busy_rd)
    );

    // Storage is not reset; a write in the reset cycle is dropped.
    assign mem_we = !reset && (bus.write_addr != '0);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.write_addr] <= bus.write_data;
        end
    end

    // Tag 0 reads as constant zero; an in-flight write to the read tag is
    // forwarded so the consumer never sees the stale value.
    always_comb begin
        rd_data_d  = '0;
        rd_ready_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_addr[i] == '0) begin
                rd_data_d[i]  = '0;
                rd_ready_d[i] = 1'b1;
            end else if (bus.rd_addr[i] == bus.write_addr) begin
                rd_data_d[i]  = bus.write_data;
                rd_ready_d[i] = 1'b1;
            end else begin
                rd_data_d[i]  = mem_q[bus.rd_addr[i]];
                rd_ready_d[i] = !busy_rd[i];
            end
        end
    end

    always_comb begin
        wakeup_valid_d = (bus.write_addr != '0);
        wakeup_tag_d   = wakeup_valid_d ? bus.write_addr : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q      <= '0;
            rd_ready_q     <= '0;
            wakeup_valid_q <= 1'b0;
            wakeup_tag_q   <= '0;
        end else begin
            rd_data_q      <= rd_data_d;
            rd_ready_q     <= rd_ready_d;
            wakeup_valid_q <= wakeup_valid_d;
            wakeup_tag_q   <= wakeup_tag_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_ready     = rd_ready_q;
    assign bus.wakeup_valid = wakeup_valid_q;
    assign bus.wakeup_tag   = wakeup_tag_q;

endmodule

// File: tb/tb_phys_reg_file.sv
// tb/tb_phys_reg_file.sv - directed vector bench for phys_reg_file
module tb_phys_reg_file;
    import phys_reg_file_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    phys_reg_file_if prf ();

    phys_reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (prf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  wa;
        logic [31:0] wd;
        logic        av;
        logic [6:0]  aa;
        logic [6:0]  r0;
        logic [6:0]  r1;
        logic        c0;     // compare rd_data[0]
        logic        c1;     // compare rd_data[1]
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;    // {port1, port0}
        logic        wv;
        logic [6:0]  wt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] wa, input logic [31:0] wd, input logic av,
                         input logic [6:0] aa, input logic [6:0] r0, input logic [6:0] r1);
        prf.write_addr  = wa;
        prf.write_data  = wd;
        prf.alloc_valid = av;
        prf.alloc_addr  = aa;
        prf.rd_addr[0]  = r0;
        prf.rd_addr[1]  = r1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(7'd0, 32'h0, 1'b0, 7'd0, 7'd0, 7'd0);

        //                wa     wd            av    aa     r0      r1      c0    c1    d0            d1            rdy    wv    wt
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd0,   7'd5,   1'b1, 1'b0, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd127, 7'd0,   1'b0, 1'b1, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'h0,        1'b1, 7'd5,  7'd5,   7'd5,   1'b0, 1'b0, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd5,   7'd0,   1'b0, 1'b1, 32'h0,        32'h0,        2'b10, 1'b0, 7'd0});
        vecs.push_back('{7'd5,  32'hDEADBEEF, 1'b0, 7'd0,  7'd0,   7'd0,   1'b1, 1'b1, 32'h0,        32'h0,        2'b11, 1'b1, 7'd5});
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd5,   7'd5,   1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'h0,        1'b1, 7'd9,  7'd0,   7'd0,   1'b1, 1'b1, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd9,  32'h1234,     1'b0, 7'd0,  7'd3,   7'd9,   1'b0, 1'b1, 32'h0,        32'h1234,     2'b11, 1'b1, 7'd9});
        vecs.push_back('{7'd0,  32'hFFFFFFFF, 1'b0, 7'd0,  7'd0,   7'd0,   1'b1, 1'b1, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'hFFFFFFFF, 1'b1, 7'd0,  7'd0,   7'd0,   1'b1, 1'b1, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'hFFFFFFFF, 1'b0, 7'd0,  7'd0,   7'd0,   1'b1, 1'b1, 32'h0,        32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd9,   7'd0,   1'b1, 1'b1, 32'h1234,     32'h0,        2'b11, 1'b0, 7'd0});
        vecs.push_back('{7'd12, 32'h55,       1'b1, 7'd12, 7'd12,  7'd12,  1'b1, 1'b1, 32'h55,       32'h55,       2'b11, 1'b1, 7'd12});
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd12,  7'd12,  1'b1, 1'b1, 32'h55,       32'h55,       2'b00, 1'b0, 7'd0});
        vecs.push_back('{7'd12, 32'h66,       1'b0, 7'd0,  7'd12,  7'd0,   1'b1, 1'b1, 32'h66,       32'h0,        2'b11, 1'b1, 7'd12});
        vecs.push_back('{7'd0,  32'h0,        1'b0, 7'd0,  7'd12,  7'd12,  1'b1, 1'b1, 32'h66,       32'h66,       2'b11, 1'b0, 7'd0});

        // Reset state
        step();
        step();
        check("reset_rd_data0", prf.rd_data[0], 32'h0);
        check("reset_rd_data1", prf.rd_data[1], 32'h0);
        check("reset_rd_ready", {30'h0, prf.rd_ready}, 32'h0);
        check("reset_wakeup_valid", {31'h0, prf.wakeup_valid}, 32'h0);
        check("reset_wakeup_tag", {25'h0, prf.wakeup_tag}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].wa, vecs[i].wd, vecs[i].av, vecs[i].aa, vecs[i].r0, vecs[i].r1);
            step();
            if (vecs[i].c0) check($sformatf("v%0d_rd_data0", i), prf.rd_data[0], vecs[i].d0);
            if (vecs[i].c1) check($sformatf("v%0d_rd_data1", i), prf.rd_data[1], vecs[i].d1);
            check($sformatf("v%0d_rd_ready", i), {30'h0, prf.rd_ready}, {30'h0, vecs[i].rdy});
            check($sformatf("v%0d_wakeup_valid", i), {31'h0, prf.wakeup_valid}, {31'h0, vecs[i].wv});
            check($sformatf("v%0d_wakeup_tag", i), {25'h0, prf.wakeup_tag}, {25'h0, vecs[i].wt});
        end

        // Reset mid-operation: busy tag 20, then reset with a write to 20
        drive(7'd0, 32'h0, 1'b1, 7'd20, 7'd0, 7'd0);
        step();
        drive(7'd0, 32'h0, 1'b0, 7'd0, 7'd20, 7'd20);
        step();
        check("midrst_busy20_ready", {30'h0, prf.rd_ready}, 32'h0);
        reset = 1'b1;
        drive(7'd20, 32'hCAFEF00D, 1'b0, 7'd0, 7'd0, 7'd0);
        step();
        check("midrst_wakeup_valid", {31'h0, prf.wakeup_valid}, 32'h0);
        check("midrst_wakeup_tag", {25'h0, prf.wakeup_tag}, 32'h0);
        check("midrst_rd_ready", {30'h0, prf.rd_ready}, 32'h0);
        check("midrst_rd_data0", prf.rd_data[0], 32'h0);
        reset = 1'b0;
        drive(7'd0, 32'h0, 1'b0, 7'd0, 7'd20, 7'd20);
        step();
        check("postrst_ready20", {30'h0, prf.rd_ready}, 32'h3);
        checks++;
        if (prf.rd_data[0] === 32'hCAFEF00D) begin
            failures++;
            $display("FAIL postrst_data20_dropped got=0x%0h must_differ_from=0xcafef00d", prf.rd_data[0]);
        end
        check("postrst_ports_equal", prf.rd_data[1], prf.rd_data[0]);
        check("postrst_wakeup_valid", {31'h0, prf.wakeup_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
